uart_tx_sched: RTL and testbench

//  Shares one uart_tx serializer between NREQ byte sources via round-robin arbitration.

---
 rtl/uart_tx_sched.sv | 137 +++++++++++++
 tb/tb_uart_tx_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx between NREQ byte sources
// Message lock keeps multi-byte messages contiguous; watchdog drops bytes the serializer never starts.
module uart_tx_sched #(
  parameter int NREQ         = 4,
  parameter int IDW          = 2,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              active,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state_q;
  logic [31:0]     cnt_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  owner_q;
  logic            lock_q;
  logic [7:0]      tx_data_q;
  logic            tx_load_q;
  logic [IDW-1:0]  grant_q;
  logic            err_q;

  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  cand;
  logic            have;
  int              idx;

  // Walk from the highest offset down so the candidate closest to ptr wins last.
  always_comb begin
    sel  = '0;
    cand = '0;
    have = 1'b0;
    idx  = 0;
    if (lock_q) begin
      sel  = owner_q;
      have = req_valid[owner_q];
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        cand = IDW'(idx);
        if (req_valid[cand]) begin
          sel  = cand;
          have = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && have) req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      grant_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (have) begin
            tx_data_q <= req_data[8*sel +: 8];
            grant_q   <= sel;
            ptr_q     <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
            owner_q   <= sel;
            lock_q    <= !req_last[sel];
            tx_load_q <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_q   <= 32'd1;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q >= 32'(BUSY_TIMEOUT)) begin
            // The byte is abandoned, so its message can no longer be held together.
            err_q  <= 1'b1;
            lock_q <= 1'b0;
            cnt_q  <= 32'd1;
            state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            cnt_q   <= 32'd1;
            state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q >= 32'(GAP_CYCLES)) state_q <= S_IDLE;
          else cnt_q <= cnt_q + 32'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_load     = tx_load_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;
  assign active      = (state_q != S_IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized bench for uart_tx_sched against a transaction-level model
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int GAP  = 4;
  localparam int BT   = 12;
  localparam int NCYC = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_load;
  logic              tx_busy;
  logic [IDW-1:0]    grant_id;
  logic              active;
  logic              err_timeout;

  logic              reset0;
  logic [1:0]        d0_valid;
  logic [15:0]       d0_data;
  logic [1:0]        d0_last;
  logic [1:0]        d0_ready;
  logic [7:0]        d0_txd;
  logic              d0_load;
  logic              d0_busy;
  logic              d0_grant;
  logic              d0_active;
  logic              d0_err;

  uart_tx_sched #(.NREQ(NREQ), .IDW(IDW), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_load(tx_load),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  uart_tx_sched #(.NREQ(2), .IDW(1), .GAP_CYCLES(0), .BUSY_TIMEOUT(8)) u_dut0 (
    .clk(clk), .reset(reset0), .req_valid(d0_valid), .req_data(d0_data),
    .req_last(d0_last), .req_ready(d0_ready), .tx_data(d0_txd), .tx_load(d0_load),
    .tx_busy(d0_busy), .grant_id(d0_grant), .active(d0_active), .err_timeout(d0_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Round-robin choice straight from the rule: first valid at distance 0,1,.. from ptr.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int d = 0; d < NREQ; d++)
      if (v[(p + d) % NREQ]) return (p + d) % NREQ;
    return -1;
  endfunction

  // Pending messages per requester
  logic [7:0] mb [NREQ][4];
  int mlen [NREQ];
  int mpos [NREQ];

  // Model of the scheduler at transaction level
  int m_ptr, m_owner, m_free, m_load_cyc, m_err_cyc, m_grant;
  bit m_lock;
  logic [7:0] m_data;
  // Serializer behaviour scheduled by the bench
  bit s_on;
  int s_rise, s_fall;
  bit rst_req, rst_done;
  int n_acc, n_tmo;

  initial begin
    logic [NREQ-1:0] exp_ready;
    int win, rise, frame;
    bit tmo, lst;
    logic [7:0] byt;

    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    reset0 = 1'b1; d0_valid = '0; d0_data = '0; d0_last = '0; d0_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin mlen[i] = 0; mpos[i] = 0; end
    mlen[0] = 1; mb[0][0] = 8'hA5;
    m_ptr = 0; m_owner = 0; m_free = 0; m_load_cyc = -1; m_err_cyc = -1; m_grant = 0;
    m_lock = 0; m_data = 8'h00; s_on = 0; s_rise = 0; s_fall = 0;
    rst_req = 0; rst_done = 0; n_acc = 0; n_tmo = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = -1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_load", 32'(tx_load), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_txdata", 32'(tx_data), 32'd0);

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      reset = rst_req;
      for (int i = 0; i < NREQ; i++) begin
        if (mpos[i] == mlen[i] && cyc >= 1 && $urandom_range(0, 5) == 0) begin
          mlen[i] = $urandom_range(1, 4);
          mpos[i] = 0;
          for (int b = 0; b < 4; b++) mb[i][b] = 8'($urandom);
        end
        req_valid[i] = (mpos[i] < mlen[i]) && (cyc < 4 || $urandom_range(0, 3) != 0);
        req_data[8*i +: 8] = (mpos[i] < mlen[i]) ? mb[i][mpos[i]] : 8'($urandom);
        req_last[i] = (mpos[i] < mlen[i]) ? (mpos[i] == mlen[i] - 1) : 1'($urandom);
      end
      tx_busy = s_on && cyc >= s_rise && cyc < s_fall;

      @(negedge clk);
      exp_ready = '0;
      win = -1;
      if (cyc >= m_free) begin
        if (m_lock) win = req_valid[m_owner] ? m_owner : -1;
        else win = rr_pick(req_valid, m_ptr);
        if (win >= 0) exp_ready[win] = 1'b1;
      end
      check_eq("ready", 32'(req_ready), 32'(exp_ready));
      check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      check_eq("tx_load", 32'(tx_load), 32'(cyc == m_load_cyc));
      check_eq("tx_data", 32'(tx_data), 32'(m_data));
      check_eq("grant_id", 32'(grant_id), 32'(m_grant));
      check_eq("err_timeout", 32'(err_timeout), 32'(cyc == m_err_cyc));
      check_eq("active", 32'(active), 32'((cyc < m_free) || m_lock));

      if (rst_req) begin
        // DUT resets at the coming edge; next cycle must look freshly reset.
        rst_req = 0; rst_done = 1;
        m_ptr = 0; m_lock = 0; m_free = cyc + 1; m_load_cyc = -1; m_err_cyc = -1;
        m_data = 8'h00; m_grant = 0; s_on = 0;
      end else if (win >= 0) begin
        byt = mb[win][mpos[win]];
        lst = (mpos[win] == mlen[win] - 1);
        mpos[win]++;
        if (n_acc == 0) begin
          tmo = 0; rise = 2; frame = 100;
        end else begin
          tmo   = ($urandom_range(0, 7) == 0);
          rise  = ($urandom_range(0, 3) == 0) ? BT : $urandom_range(1, 3);
          frame = $urandom_range(1, 8);
        end
        n_acc++;
        m_load_cyc = cyc + 1;
        m_data  = byt;
        m_grant = win;
        m_ptr   = (win + 1) % NREQ;
        m_owner = win;
        m_lock  = tmo ? 1'b0 : !lst;
        if (tmo) begin
          n_tmo++;
          s_on = 0;
          m_err_cyc = m_load_cyc + BT + 1;
          m_free = m_err_cyc + GAP;
        end else begin
          s_on   = 1;
          s_rise = m_load_cyc + rise;
          s_fall = s_rise + frame;
          m_free = s_fall + GAP + 1;
        end
      end
      if (!rst_done && cyc > 2500 && m_lock && s_on && cyc >= s_rise + 1 && cyc + 1 < s_fall)
        rst_req = 1;
    end
    check_eq("reset_injected", 32'(rst_done), 32'd1);
    check_eq("timeouts_seen", 32'(n_tmo > 0), 32'd1);

    // Zero-gap build: the next accept follows the busy fall by one cycle.
    begin
      int free0, acc0, f0;
      logic [7:0] b0;
      free0 = 0; acc0 = -10; f0 = 0; b0 = 8'h00;
      for (cyc = 0; cyc < 200; cyc++) begin
        @(posedge clk); #1;
        reset0 = 1'b0;
        d0_valid = 2'b01;
        d0_data  = 16'($urandom);
        d0_last  = 2'b11;
        d0_busy  = (acc0 >= 0) && cyc >= acc0 + 2 && cyc < f0;
        @(negedge clk);
        check_eq("g0_ready", 32'(d0_ready), (cyc >= free0) ? 32'd1 : 32'd0);
        check_eq("g0_load", 32'(d0_load), 32'(cyc == acc0 + 1));
        if (cyc == acc0 + 1) begin
          check_eq("g0_txdata", 32'(d0_txd), 32'(b0));
          f0 = cyc + 1 + $urandom_range(1, 5);
          free0 = f0 + 1;
        end else if (cyc >= free0) begin
          acc0 = cyc;
          b0 = d0_data[7:0];
          free0 = 1 << 30;
        end
      end
      check_eq("g0_err", 32'(d0_err), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
